rr_enc_arbiter: RTL

RR_ENC_ARBITER -- requirements
Module: rr_enc_arbiter

---
 rtl/rr_enc_arbiter_pkg.sv | 13 +
 rtl/enc_onehot.sv | 20 ++
 rtl/rr_enc_arbiter.sv | 102 ++++++++++
 3 files changed

// File: rtl/rr_enc_arbiter_pkg.sv
// Shared constants for the rotating-priority arbiter: default sizes and FSM states.
package rr_enc_arbiter_pkg;

  localparam int unsigned RR_N_DEFAULT = 4;  // requesters, must be 2**k
  localparam int unsigned RR_K_DEFAULT = 2;  // grant index width
  localparam int unsigned RR_H_DEFAULT = 4;  // hold counter width

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } rr_state_t;

endpackage : rr_enc_arbiter_pkg

// File: rtl/enc_onehot.sv
// One-hot to binary encoder; an all-zero input encodes to index 0.
module enc_onehot #(
  parameter int unsigned n = 4,
  parameter int unsigned k = 2
) (
  input  logic [n-1:0] i_onehot,
  output logic [k-1:0] o_idx
);

  // OR together the indices of all set bits (exactly one for a valid one-hot input)
  always_comb begin
    o_idx = '0;
    for (int i = 0; i < int'(n); i++) begin
      if (i_onehot[i]) begin
        o_idx = o_idx | k'(i);
      end
    end
  end

endmodule : enc_onehot

// File: rtl/rr_enc_arbiter.sv
// Rotating-priority arbiter with registered one-hot grant, binary index and
// a bounded hold time after which the grant is revoked with a timeout pulse.
module rr_enc_arbiter
  import rr_enc_arbiter_pkg::*;
#(
  parameter int unsigned n = RR_N_DEFAULT,
  parameter int unsigned k = RR_K_DEFAULT,
  parameter int unsigned h = RR_H_DEFAULT
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [n-1:0] req,
  output logic [n-1:0] gnt,
  output logic [k-1:0] gnt_idx,
  output logic         valid,
  output logic         timeout
);

  // Hold counter value during the last permitted grant cycle (2**h-1 cycles total)
  localparam logic [h-1:0] HOLD_LAST = h'((1 << h) - 2);

  rr_state_t    r_state;
  logic [n-1:0] r_gnt;
  logic [k-1:0] r_gnt_idx;
  logic         r_valid;
  logic         r_timeout;
  logic [k-1:0] r_ptr;
  logic [h-1:0] r_hold;

  logic [n-1:0] w_sel_oh;
  logic [k-1:0] w_sel_idx;

  // Pick the first requester at or after r_ptr, wrapping; lowest search offset wins
  always_comb begin
    logic [k-1:0] w_pos;
    w_sel_oh = '0;
    w_pos    = '0;
    for (int j = int'(n) - 1; j >= 0; j--) begin
      w_pos = r_ptr + k'(j);
      if (req[w_pos]) begin
        w_sel_oh        = '0;
        w_sel_oh[w_pos] = 1'b1;
      end
    end
  end

  enc_onehot #(
    .n (n),
    .k (k)
  ) u_enc (
    .i_onehot (w_sel_oh),
    .o_idx    (w_sel_idx)
  );

  // Arbiter FSM: grant from IDLE, hold while requested, release or time out back to IDLE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_gnt     <= '0;
      r_gnt_idx <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_ptr     <= '0;
      r_hold    <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (|req) begin
            r_gnt     <= w_sel_oh;
            r_gnt_idx <= w_sel_idx;
            r_valid   <= 1'b1;
            r_hold    <= '0;
            r_state   <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (!req[r_gnt_idx] || (r_hold == HOLD_LAST)) begin
            // Voluntary release takes precedence: no timeout if req drops on the last cycle
            r_timeout <= req[r_gnt_idx];
            r_gnt     <= '0;
            r_gnt_idx <= '0;
            r_valid   <= 1'b0;
            r_ptr     <= r_gnt_idx + k'(1);
            r_state   <= ST_IDLE;
          end else begin
            r_hold <= r_hold + h'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign gnt_idx = r_gnt_idx;
  assign valid   = r_valid;
  assign timeout = r_timeout;

endmodule : rr_enc_arbiter
